// File: rtl/tdm_demux_pkg.sv
// Shared constants for the 1-to-4 TDM demultiplexer: slot width, FSM encoding and
// the channel-slice offset helper used to pack channel words onto one bus.
package tdm_demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  localparam logic [SLOT_W-1:0] FIRST_SLOT = SLOT_W'(0);
  localparam logic [SLOT_W-1:0] NEXT_SLOT  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_CH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Channel k lives at bits [k*data_w +: data_w] of the packed channel bus.
  function automatic int ch_offset(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// Bus bundle between a serial word source, the demux and its channel consumers.
// Parity signals exist only when TDM_DEMUX_PARITY_EN is defined.
interface tdm_demux4_if #(
  parameter int DATA_W = 8
);

  logic                in_valid_i;
  logic                sync_i;
  logic [DATA_W-1:0]   in_data_i;
  logic [4*DATA_W-1:0] ch_data_o;
  logic [3:0]          ch_strobe_o;
  logic [1:0]          sel_o;
  logic                frame_done_o;
  logic                sync_err_o;
`ifdef TDM_DEMUX_PARITY_EN
  logic                in_par_i;
  logic                par_err_o;
`endif

  modport master (
    output in_valid_i, sync_i, in_data_i,
`ifdef TDM_DEMUX_PARITY_EN
    output in_par_i,
    input  par_err_o,
`endif
    input  ch_data_o, ch_strobe_o, sel_o, frame_done_o, sync_err_o
  );

  modport slave (
    input  in_valid_i, sync_i, in_data_i,
`ifdef TDM_DEMUX_PARITY_EN
    input  in_par_i,
    output par_err_o,
`endif
    output ch_data_o, ch_strobe_o, sel_o, frame_done_o, sync_err_o
  );

endinterface

// File: rtl/tdm_slot_dec.sv
// Combinational 2-to-4 one-hot decoder turning the write slot into per-channel
// write enables; all enables are low unless the word is being accepted.
module tdm_slot_dec
  import tdm_demux_pkg::*;
(
  input  logic [SLOT_W-1:0] slot_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] we_o
);

  always_comb begin
    we_o = '0;
    if (en_i) begin
      we_o[slot_i] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// 1-to-4 time-division demultiplexer: steers sync-framed serial words round-robin into
// four registered channels. Optional even-parity check under TDM_DEMUX_PARITY_EN.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  logic [0:0]           state_q, state_d;
  logic [SLOT_W-1:0]    sel_q, sel_d;
  logic [NUM_CH-1:0]    strobe_q;
  logic                 frame_done_q, frame_done_d;
  logic                 sync_err_q, sync_err_d;
  logic [DATA_W-1:0]    ch_q [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] ch_packed;

  logic                 accept;
  logic [SLOT_W-1:0]    wr_slot;
  logic [NUM_CH-1:0]    we;

  // A word is stored when it starts a frame or continues one; a sync word always lands in slot 0.
  assign accept  = bus.in_valid_i & (bus.sync_i | (state_q == RUN));
  assign wr_slot = bus.sync_i ? FIRST_SLOT : sel_q;

  tdm_slot_dec u_slot_dec (
    .slot_i (wr_slot),
    .en_i   (accept),
    .we_o   (we)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    if (bus.in_valid_i) begin
      if (bus.sync_i) begin
        // Sync inside a frame means the previous frame was cut short.
        sync_err_d = (state_q == RUN);
        sel_d      = NEXT_SLOT;
        state_d    = RUN;
      end else if (state_q == IDLE) begin
        sync_err_d = 1'b1;
      end else begin
        sel_d = sel_q + NEXT_SLOT;
        if (sel_q == LAST_SLOT) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= FIRST_SLOT;
      strobe_q     <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      strobe_q     <= we;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Unwritten channels hold their value, including leftovers from an aborted frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        ch_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (we[k]) begin
          ch_q[k] <= bus.in_data_i;
        end
      end
    end
  end

  always_comb begin
    ch_packed = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_packed[ch_offset(k, DATA_W) +: DATA_W] = ch_q[k];
    end
  end

  assign bus.ch_data_o    = ch_packed;
  assign bus.ch_strobe_o  = strobe_q;
  assign bus.sel_o        = sel_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.sync_err_o   = sync_err_q;

`ifdef TDM_DEMUX_PARITY_EN
  logic par_err_q, par_err_d;

  // Even parity over {par, data}: an odd total flags the word, which is still stored.
  assign par_err_d = accept & (^{bus.in_par_i, bus.in_data_i});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign bus.par_err_o = par_err_q;
`endif

endmodule
